// File: rtl/rlnn_step_controller.sv
// Sequences one RL agent step through the NN wrapper: model forward, argmax action,
// optional target forward, TD-loss and training pass, with a per-wait timeout abort.
module rlnn_step_controller #(
    parameter int DATA_WIDTH          = 4,
    parameter int COUNT               = 4,
    parameter int NEURON_INPUT_LAYER  = 2,
    parameter int NEURON_OUTPUT_LAYER = 2,
    parameter int TIMEOUT             = 255,
    localparam int ACT_W = (NEURON_OUTPUT_LAYER > 1) ? $clog2(NEURON_OUTPUT_LAYER) : 1
) (
    input  logic                                      clk,
    input  logic                                      rst_b,
    input  logic                                      start,
    input  logic [NEURON_INPUT_LAYER*DATA_WIDTH-1:0]  state_in,
    input  logic [DATA_WIDTH-1:0]                     reward,
    input  logic                                      train_en,
    output logic                                      busy,
    output logic                                      step_done,
    output logic [ACT_W-1:0]                          action,
    output logic [NEURON_OUTPUT_LAYER*DATA_WIDTH-1:0] q_out,
    output logic                                      timeout_err,
    output logic [NEURON_INPUT_LAYER*DATA_WIDTH-1:0]  nn_input,
    output logic                                      input_enable,
    output logic                                      use_target,
    output logic                                      is_training,
    output logic [COUNT*DATA_WIDTH-1:0]               loss,
    input  logic [NEURON_OUTPUT_LAYER*DATA_WIDTH-1:0] nn_inf_output,
    input  logic                                      model_fwd_done,
    input  logic                                      target_fwd_done,
    input  logic                                      training_done
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MODEL_FWD, S_SELECT, S_TARGET_FWD, S_LOSS, S_TRAIN, S_DONE
    } state_t;

    state_t                                    r_state;
    logic [CNT_W-1:0]                          r_waitCnt;
    logic                                      r_modelPrev, r_targetPrev, r_trainPrev;
    logic [DATA_WIDTH-1:0]                     r_reward;
    logic                                      r_trainEn;
    logic [DATA_WIDTH-1:0]                     r_tmax;
    logic                                      r_busy, r_stepDone, r_timeoutErr;
    logic [ACT_W-1:0]                          r_action;
    logic [NEURON_OUTPUT_LAYER*DATA_WIDTH-1:0] r_qOut;
    logic [NEURON_INPUT_LAYER*DATA_WIDTH-1:0]  r_nnInput;
    logic                                      r_inputEnable, r_useTarget, r_isTraining;
    logic [COUNT*DATA_WIDTH-1:0]               r_loss;

    logic                  w_modelRise, w_targetRise, w_trainRise, w_waitExpired;
    logic [ACT_W-1:0]      w_argIdx;
    logic [DATA_WIDTH-1:0] w_argVal, w_infMax, w_qSel, w_td;
    logic [DATA_WIDTH:0]   w_sum, w_qExt, w_diff;
    logic [COUNT*DATA_WIDTH-1:0] w_lossNext;

    assign w_modelRise   = model_fwd_done  & ~r_modelPrev;
    assign w_targetRise  = target_fwd_done & ~r_targetPrev;
    assign w_trainRise   = training_done   & ~r_trainPrev;
    assign w_waitExpired = (r_waitCnt == CNT_W'(TIMEOUT - 1));

    // Argmax with strict compare so ties resolve to the lowest index.
    always_comb begin
        w_argIdx = '0;
        w_argVal = r_qOut[0 +: DATA_WIDTH];
        for (int i = 1; i < NEURON_OUTPUT_LAYER; i++) begin
            if (r_qOut[i*DATA_WIDTH +: DATA_WIDTH] > w_argVal) begin
                w_argVal = r_qOut[i*DATA_WIDTH +: DATA_WIDTH];
                w_argIdx = ACT_W'(i);
            end
        end
    end

    always_comb begin
        w_infMax = nn_inf_output[0 +: DATA_WIDTH];
        for (int i = 1; i < NEURON_OUTPUT_LAYER; i++) begin
            if (nn_inf_output[i*DATA_WIDTH +: DATA_WIDTH] > w_infMax)
                w_infMax = nn_inf_output[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        w_qSel = r_qOut[0 +: DATA_WIDTH];
        for (int i = 1; i < NEURON_OUTPUT_LAYER; i++) begin
            if (r_action == ACT_W'(i))
                w_qSel = r_qOut[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // TD error at one extra bit so reward+tmax cannot wrap before saturation.
    always_comb begin
        w_sum  = {1'b0, r_reward} + {1'b0, r_tmax};
        w_qExt = {1'b0, w_qSel};
        w_diff = (w_sum >= w_qExt) ? (w_sum - w_qExt) : (w_qExt - w_sum);
        w_td   = w_diff[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : w_diff[DATA_WIDTH-1:0];
        w_lossNext = '0;
        w_lossNext[0 +: DATA_WIDTH] = w_td;
        w_lossNext[DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(r_action);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_modelPrev  <= 1'b0;
            r_targetPrev <= 1'b0;
            r_trainPrev  <= 1'b0;
        end else begin
            r_modelPrev  <= model_fwd_done;
            r_targetPrev <= target_fwd_done;
            r_trainPrev  <= training_done;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_waitCnt     <= '0;
            r_reward      <= '0;
            r_trainEn     <= 1'b0;
            r_tmax        <= '0;
            r_busy        <= 1'b0;
            r_stepDone    <= 1'b0;
            r_timeoutErr  <= 1'b0;
            r_action      <= '0;
            r_qOut        <= '0;
            r_nnInput     <= '0;
            r_inputEnable <= 1'b0;
            r_useTarget   <= 1'b0;
            r_isTraining  <= 1'b0;
            r_loss        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_reward      <= reward;
                        r_trainEn     <= train_en;
                        r_timeoutErr  <= 1'b0;
                        r_nnInput     <= state_in;
                        r_inputEnable <= 1'b1;
                        r_busy        <= 1'b1;
                        r_waitCnt     <= '0;
                        r_state       <= S_MODEL_FWD;
                    end
                end
                S_MODEL_FWD: begin
                    if (w_modelRise) begin
                        r_qOut        <= nn_inf_output;
                        r_inputEnable <= 1'b0;
                        r_state       <= S_SELECT;
                    end else if (w_waitExpired) begin
                        r_timeoutErr  <= 1'b1;
                        r_inputEnable <= 1'b0;
                        r_stepDone    <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_SELECT: begin
                    r_action <= w_argIdx;
                    if (r_trainEn) begin
                        r_useTarget <= 1'b1;
                        r_waitCnt   <= '0;
                        r_state     <= S_TARGET_FWD;
                    end else begin
                        r_stepDone <= 1'b1;
                        r_state    <= S_DONE;
                    end
                end
                S_TARGET_FWD: begin
                    if (w_targetRise) begin
                        r_tmax  <= w_infMax;
                        r_state <= S_LOSS;
                    end else if (w_waitExpired) begin
                        r_timeoutErr <= 1'b1;
                        r_useTarget  <= 1'b0;
                        r_stepDone   <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_LOSS: begin
                    r_loss       <= w_lossNext;
                    r_isTraining <= 1'b1;
                    r_waitCnt    <= '0;
                    r_state      <= S_TRAIN;
                end
                S_TRAIN: begin
                    if (w_trainRise || w_waitExpired) begin
                        r_timeoutErr <= ~w_trainRise;
                        r_useTarget  <= 1'b0;
                        r_isTraining <= 1'b0;
                        r_stepDone   <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_stepDone <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign step_done    = r_stepDone;
    assign action       = r_action;
    assign q_out        = r_qOut;
    assign timeout_err  = r_timeoutErr;
    assign nn_input     = r_nnInput;
    assign input_enable = r_inputEnable;
    assign use_target   = r_useTarget;
    assign is_training  = r_isTraining;
    assign loss         = r_loss;

endmodule

// File: tb/tb_rlnn_step_controller.sv
// Directed bench for rlnn_step_controller: inference, training, saturation, ties,
// stale done strobes, timeout and asynchronous reset mid-step.
module tb_rlnn_step_controller;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        start;
    logic [7:0]  state_in;
    logic [3:0]  reward;
    logic        train_en;
    logic        busy, step_done, timeout_err;
    logic [0:0]  action;
    logic [7:0]  q_out, nn_input;
    logic        input_enable, use_target, is_training;
    logic [15:0] loss;
    logic [7:0]  nn_inf_output;
    logic        model_fwd_done, target_fwd_done, training_done;

    int vectorCount = 0;
    int missCount   = 0;

    rlnn_step_controller dut (
        .clk(clk), .rst_b(rst_b), .start(start), .state_in(state_in),
        .reward(reward), .train_en(train_en), .busy(busy), .step_done(step_done),
        .action(action), .q_out(q_out), .timeout_err(timeout_err),
        .nn_input(nn_input), .input_enable(input_enable), .use_target(use_target),
        .is_training(is_training), .loss(loss), .nn_inf_output(nn_inf_output),
        .model_fwd_done(model_fwd_done), .target_fwd_done(target_fwd_done),
        .training_done(training_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] st, input logic [3:0] rw, input logic te);
        state_in = st;
        reward   = rw;
        train_en = te;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic waitStepDone(input int limit, output int cycles);
        cycles = 0;
        while (!step_done && cycles < limit) begin
            tick();
            cycles++;
        end
        if (!step_done) checkOutput("stepDoneWait", 0, 1);
    endtask

    initial begin
        int cycles;
        bit sawFlag;
        rst_b = 1'b0; start = 1'b0; state_in = '0; reward = '0; train_en = 1'b0;
        nn_inf_output = '0; model_fwd_done = 1'b0; target_fwd_done = 1'b0;
        training_done = 1'b0;
        tick(); tick();
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetLoss", loss, 0);
        checkOutput("resetQ", q_out, 0);
        rst_b = 1'b1;
        tick();

        $display("[TB] inference-only step");
        applyStimulus(8'h21, 4'd0, 1'b0);
        checkOutput("infNnInput", nn_input, 8'h21);
        checkOutput("infInputEn", input_enable, 1);
        checkOutput("infBusy", busy, 1);
        tick(); tick();
        nn_inf_output = 8'h52; model_fwd_done = 1'b1;
        tick();
        checkOutput("infQOut", q_out, 8'h52);
        checkOutput("infInputEnLow", input_enable, 0);
        checkOutput("infNoDoneYet", step_done, 0);
        tick();
        checkOutput("infStepDone", step_done, 1);
        checkOutput("infAction", action, 1);
        checkOutput("infUseTarget", use_target, 0);
        tick();
        checkOutput("infDonePulse", step_done, 0);
        checkOutput("infBusyLow", busy, 0);
        model_fwd_done = 1'b0;
        tick();

        $display("[TB] tie step, done left high afterwards");
        applyStimulus(8'h10, 4'd0, 1'b0);
        nn_inf_output = 8'h44; model_fwd_done = 1'b1;
        waitStepDone(10, cycles);
        checkOutput("tieAction", action, 0);
        tick(); tick();

        $display("[TB] stale done strobe");
        nn_inf_output = 8'h25;
        applyStimulus(8'h33, 4'd0, 1'b0);
        tick(); tick(); tick();
        checkOutput("staleNoCapture", q_out, 8'h44);
        checkOutput("staleBusy", busy, 1);
        applyStimulus(8'hAB, 4'd0, 1'b1);
        checkOutput("busyStartIgnored", nn_input, 8'h33);
        model_fwd_done = 1'b0;
        tick();
        model_fwd_done = 1'b1;
        tick();
        checkOutput("freshCapture", q_out, 8'h25);
        tick();
        checkOutput("staleStepDone", step_done, 1);
        checkOutput("staleUseTarget", use_target, 0);
        model_fwd_done = 1'b0;
        tick(); tick();

        $display("[TB] full training step");
        applyStimulus(8'h12, 4'd4, 1'b1);
        nn_inf_output = 8'h52; model_fwd_done = 1'b1;
        tick(); tick();
        checkOutput("trainUseTarget", use_target, 1);
        checkOutput("trainAction", action, 1);
        model_fwd_done = 1'b0;
        nn_inf_output = 8'h31; target_fwd_done = 1'b1;
        tick(); tick();
        checkOutput("trainLoss", loss, 16'h0012);
        checkOutput("trainIsTraining", is_training, 1);
        tick(); tick();
        checkOutput("trainHold", is_training, 1);
        checkOutput("trainNoDone", step_done, 0);
        training_done = 1'b1;
        tick();
        checkOutput("trainStepDone", step_done, 1);
        checkOutput("trainIsTrainingLow", is_training, 0);
        checkOutput("trainUseTargetLow", use_target, 0);
        checkOutput("trainNoErr", timeout_err, 0);
        target_fwd_done = 1'b0; training_done = 1'b0;
        tick(); tick();

        $display("[TB] saturation step");
        applyStimulus(8'h00, 4'd15, 1'b1);
        nn_inf_output = 8'h00; model_fwd_done = 1'b1;
        tick(); tick();
        model_fwd_done = 1'b0;
        nn_inf_output = 8'hFF; target_fwd_done = 1'b1;
        tick(); tick();
        checkOutput("satLoss", loss, 16'h000F);
        checkOutput("satAction", action, 0);
        training_done = 1'b1;
        waitStepDone(10, cycles);
        target_fwd_done = 1'b0; training_done = 1'b0;
        tick(); tick();

        $display("[TB] model forward timeout");
        applyStimulus(8'h77, 4'd0, 1'b0);
        waitStepDone(400, cycles);
        checkOutput("timeoutCycles", cycles, 255);
        checkOutput("timeoutErr", timeout_err, 1);
        checkOutput("timeoutInputEn", input_enable, 0);
        checkOutput("timeoutQHeld", q_out, 8'h00);
        checkOutput("timeoutLossHeld", loss, 16'h000F);
        tick(); tick();
        checkOutput("timeoutErrSticky", timeout_err, 1);
        applyStimulus(8'h21, 4'd3, 1'b1);
        checkOutput("timeoutErrCleared", timeout_err, 0);

        $display("[TB] reset during training");
        nn_inf_output = 8'h52; model_fwd_done = 1'b1;
        tick(); tick();
        model_fwd_done = 1'b0;
        nn_inf_output = 8'h31; target_fwd_done = 1'b1;
        tick(); tick(); tick();
        checkOutput("preResetTraining", is_training, 1);
        #2 rst_b = 1'b0;
        #1;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstIsTraining", is_training, 0);
        checkOutput("rstUseTarget", use_target, 0);
        checkOutput("rstLoss", loss, 0);
        checkOutput("rstQ", q_out, 0);
        checkOutput("rstNnInput", {input_enable, nn_input}, 0);
        tick();
        rst_b = 1'b1;
        target_fwd_done = 1'b0;
        sawFlag = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (step_done || busy) sawFlag = 1'b1;
        end
        checkOutput("rstNoStepDone", sawFlag, 0);

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/rlnn_step_controller.md
Name: rlnn_step_controller

Overview:
- Hardware initiator for the RL neural-network top wrapper. It drives the wrapper's input, target, loss and training controls, and consumes its done strobes and inference output.
- Runs one agent step per `start`: model forward pass, action selection (argmax), optional target forward pass, TD-loss computation, then a training pass.
- Sits between the environment/agent logic and the NN wrapper. It replaces manual bench sequencing of `input_enable`, `use_target`, `is_training` and `loss`.

Parameters:
- DATA_WIDTH, 4: width of each NN value slice (unsigned).
- COUNT, 4: number of DATA_WIDTH slices in `loss`.
- NEURON_INPUT_LAYER, 2: input slices.
- NEURON_OUTPUT_LAYER, 2: output slices (Q-values), must be ≥2.
- TIMEOUT, 255: maximum cycles spent in any wait state before abort.
- ACT_W (localparam): $clog2(NEURON_OUTPUT_LAYER), minimum 1.

Ports:
- clk  in  1  clock; all logic is on posedge.
- rst_b  in  1  reset, asynchronous, active-low.
- start  in  1  begin a step; sampled only in IDLE.
- state_in  in  NEURON_INPUT_LAYER*DATA_WIDTH  observation; latched on accepted start.
- reward  in  DATA_WIDTH  reward; latched on accepted start.
- train_en  in  1  run target and training phases; latched on accepted start.
- busy  out  1  step in progress.
- step_done  out  1  one-cycle pulse at end of step, including aborts.
- action  out  ACT_W  selected action index.
- q_out  out  NEURON_OUTPUT_LAYER*DATA_WIDTH  captured model output.
- timeout_err  out  1  sticky abort flag; cleared on next accepted start.
- nn_input  out  NEURON_INPUT_LAYER*DATA_WIDTH  to wrapper.
- input_enable  out  1  to wrapper.
- use_target  out  1  to wrapper.
- is_training  out  1  to wrapper.
- loss  out  COUNT*DATA_WIDTH  to wrapper.
- nn_inf_output  in  NEURON_OUTPUT_LAYER*DATA_WIDTH  from wrapper.
- model_fwd_done  in  1  from wrapper.
- target_fwd_done  in  1  from wrapper.
- training_done  in  1  from wrapper.

Behaviour:
- **Reset:** every output and internal register resets to 0; FSM goes to IDLE. Reset asserted mid-step aborts immediately, with no step_done.
- **Done strobes:** all three are rising-edge detected against a registered previous value (reset 0). A done held high from an earlier step does not trigger.
- **FSM states:** IDLE, MODEL_FWD, SELECT, TARGET_FWD, LOSS, TRAIN, DONE.
- **IDLE:**
  - start=1 latches state_in, reward and train_en, and clears timeout_err.
  - Next cycle: MODEL_FWD, busy=1, nn_input=latched state, input_enable=1.
  - start while busy is ignored.
- **MODEL_FWD:** on a model_fwd_done rise, capture nn_inf_output into q_out, then go to SELECT.
- **SELECT (1 cycle):**
  - input_enable=0.
  - action = argmax of q_out slices (slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]); ties go to the lowest index.
  - If latched train_en=0 go to DONE, else TARGET_FWD.
- **TARGET_FWD:** use_target=1; on a target_fwd_done rise, capture tmax = max of nn_inf_output slices, then go to LOSS.
- **LOSS (1 cycle):**
  - td = |(reward + tmax) − q_out[action]|, computed at DATA_WIDTH+1 bits, saturated to 2^DATA_WIDTH−1.
  - loss slice0 = td; slice1 = action zero-extended; all other slices = 0.
  - loss is registered here and held stable until the next accepted start.
- **TRAIN:** use_target=1, is_training=1; on a training_done rise go to DONE.
- **DONE (1 cycle):** step_done=1; use_target=0, is_training=0; busy=0 from the next cycle; return to IDLE.
- **Timeout:**
  - A wait counter clears on entry to MODEL_FWD, TARGET_FWD and TRAIN.
  - When it reaches TIMEOUT without the expected edge: set timeout_err=1, deassert input_enable, use_target and is_training, go to DONE (step_done pulses).
  - q_out, action and loss keep their last values.
- **Simultaneous events:** a done edge arriving in the same cycle the counter reaches TIMEOUT counts as success, not timeout.
- **Unexpected done edges:** done edges arriving in the wrong state are ignored.
- **Output latency:** nn_input and input_enable are high exactly 1 cycle after start; step_done occurs at least 3 cycles after start (train_en=0).

Test Plan:
- **Reset:** rst_b=0 mid-TRAIN → all outputs 0 asynchronously, FSM IDLE, no step_done after release.
- **Inference-only step:**
  - Stimulus: train_en=0, state_in=8'h21, wrapper returns nn_inf_output=8'h52 with model_fwd_done.
  - Response: nn_input=8'h21 with input_enable=1 the cycle after start; action=1; q_out=8'h52; step_done 2 cycles after the done edge; use_target never asserted.
- **Full training step:**
  - Stimulus: train_en=1, reward=4, model output 8'h52, target output 8'h31.
  - Response: td=|4+3−5|=2 → loss=16'h0012; is_training high until the training_done rise; then step_done.
- **Saturation and ties:**
  - Model output 8'h00, target 8'hFF, reward=15 → loss slice0=4'hF (not wrapped).
  - Model output 8'h44 → action=0.
- **Timeout:** model_fwd_done never rises, TIMEOUT=255 → timeout_err=1 and step_done 255 cycles after MODEL_FWD entry; input_enable=0; next start clears timeout_err.
- **Stale done:** model_fwd_done held high from the previous step → no capture until a fresh 0→1 edge; start pulsed while busy → ignored.
